// File: rtl/countdown_pkg.sv
// Shared types and limits for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_e;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned CS_W  = 7;

    localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
    localparam logic [CS_W-1:0]  MAX_CS  = 7'd99;

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v);
        return (v > MAX_SEC) ? MAX_SEC : v;
    endfunction

    function automatic logic [CS_W-1:0] clamp_cs(input logic [CS_W-1:0] v);
        return (v > MAX_CS) ? MAX_CS : v;
    endfunction

endpackage

// File: rtl/countdown_timer_counter.sv
// Modulo-MODULUS prescaler with enable, synchronous clear and a carry-out
// that is high on the enabled cycle in which the count wraps.
module countdown_timer_counter #(
    parameter int unsigned MODULUS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic carry
);

    localparam int unsigned W = (MODULUS > 2) ? $clog2(MODULUS) : 1;
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign carry = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting sec.centisec timer with start/pause (k0) and clear (k1) keys.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the preset on expiry and keep running.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             k0,
    input  logic             k1,
    input  logic [SEC_W-1:0] preset_sec,
    input  logic [CS_W-1:0]  preset_cs,
    output logic [SEC_W-1:0] sec,
    output logic [CS_W-1:0]  centisec,
    output logic             running,
    output logic             expired,
    output logic             alarm
);

    cd_state_e        state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             alarm_q, alarm_d;

    logic             tick;
    logic             presc_en;
    logic             presc_clr;
    logic [SEC_W-1:0] pre_sec;
    logic [CS_W-1:0]  pre_cs;
    logic             pre_zero;
    logic             val_zero;
    logic             val_one;

    assign pre_sec  = clamp_sec(preset_sec);
    assign pre_cs   = clamp_cs(preset_cs);
    assign pre_zero = (pre_sec == '0) && (pre_cs == '0);
    assign val_zero = (sec_q == '0) && (cs_q == '0);
    assign val_one  = (sec_q == '0) && (cs_q == CS_W'(1));

    assign presc_en  = (state_q == RUN);
    assign presc_clr = (state_d == IDLE) || (state_d == DONE);

    countdown_timer_counter #(
        .MODULUS(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (presc_en),
        .clr  (presc_clr),
        .carry(tick)
    );

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        alarm_d = 1'b0;

        if (k1) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (k0 && !pre_zero) state_d = RUN;
                end
                RUN: begin
                    // Zero is reached by a tick, and expiry is resolved on the
                    // following cycle so the alarm lands one cycle after 00.00.
                    if (val_zero) begin
                        alarm_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (pre_zero) begin
                            state_d = DONE;
                        end else begin
                            sec_d = pre_sec;
                            cs_d  = pre_cs;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        if (tick) begin
                            if (cs_q == '0) begin
                                cs_d  = MAX_CS;
                                sec_d = sec_q - 1'b1;
                            end else begin
                                cs_d = cs_q - 1'b1;
                            end
                        end
                        if (k0 && !(tick && val_one)) state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (k0) state_d = RUN;
                end
                DONE: begin
                    sec_d = '0;
                    cs_d  = '0;
                    if (k0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_q == IDLE || state_d == IDLE) begin
            sec_d = pre_sec;
            cs_d  = pre_cs;
        end

        running_d = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            cs_q      <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            cs_q      <= cs_d;
            running_q <= running_d;
            expired_q <= expired_d;
            alarm_q   <= alarm_d;
        end
    end

    assign sec      = sec_q;
    assign centisec = cs_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected snapshots per
// cycle, a negedge monitor pops and compares them.
module tb_countdown_timer;

    localparam int unsigned CLK_DIV = 10;
    localparam int unsigned DEADLINE = 400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       k0;
    logic       k1;
    logic [5:0] preset_sec;
    logic [6:0] preset_cs;
    logic [5:0] sec;
    logic [6:0] centisec;
    logic       running;
    logic       expired;
    logic       alarm;

    countdown_timer #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k0        (k0),
        .k1        (k1),
        .preset_sec(preset_sec),
        .preset_cs (preset_cs),
        .sec       (sec),
        .centisec  (centisec),
        .running   (running),
        .expired   (expired),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned s;
        int unsigned cs;
        bit          run;
        bit          exp;
        bit          alm;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_x;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued snapshot due at or before this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && (sb_q[0].cyc <= cyc || cyc >= DEADLINE)) begin
            mon_x = sb_q.pop_front();
            n_cmp++;
            if (mon_x.cyc != cyc) begin
                n_err++;
                $display("FAIL late_check: due cycle %0d, compared at cycle %0d", mon_x.cyc, cyc);
            end else if (sec !== 6'(mon_x.s) || centisec !== 7'(mon_x.cs) ||
                         running !== mon_x.run || expired !== mon_x.exp || alarm !== mon_x.alm) begin
                n_err++;
                $display("FAIL snapshot cyc %0d: got %0d.%0d run=%b exp=%b alm=%b, want %0d.%0d run=%b exp=%b alm=%b",
                         cyc, sec, centisec, running, expired, alarm,
                         mon_x.s, mon_x.cs, mon_x.run, mon_x.exp, mon_x.alm);
            end
        end
    end

    task automatic expect_at(input int unsigned c, input int unsigned s, input int unsigned cs,
                             input bit r, input bit e, input bit a);
        exp_t x;
        x.cyc = c; x.s = s; x.cs = cs; x.run = r; x.exp = e; x.alm = a;
        sb_q.push_back(x);
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input logic a, input logic b, input int unsigned c);
        wait_to(c);
        k0 = a;
        k1 = b;
        wait_to(c + 1);
        k0 = 1'b0;
        k1 = 1'b0;
    endtask

    task automatic set_preset(input int unsigned c, input logic [5:0] s, input logic [6:0] cs);
        wait_to(c);
        preset_sec = s;
        preset_cs  = cs;
    endtask

    initial begin
        rst_n = 1'b0;
        k0 = 1'b0;
        k1 = 1'b0;
        preset_sec = 6'd0;
        preset_cs  = 7'd3;

        // Reset state, then 00.03 countdown with k0 at cycle 5.
        expect_at(2, 0, 0, 0, 0, 0);
        expect_at(3, 0, 0, 0, 0, 0);
        expect_at(5, 0, 3, 0, 0, 0);
        expect_at(6, 0, 3, 1, 0, 0);
        expect_at(15, 0, 3, 1, 0, 0);
        expect_at(16, 0, 2, 1, 0, 0);
        expect_at(26, 0, 1, 1, 0, 0);
        expect_at(36, 0, 0, 1, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        expect_at(37, 0, 3, 1, 0, 1);
        expect_at(38, 0, 3, 1, 0, 0);
`else
        expect_at(37, 0, 0, 0, 1, 1);
        expect_at(38, 0, 0, 0, 1, 0);
`endif
        wait_to(4);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 5);

        // Clear with k1 reloads 01.00, then borrow path.
        expect_at(40, 1, 0, 0, 0, 0);
        expect_at(42, 1, 0, 1, 0, 0);
        expect_at(51, 1, 0, 1, 0, 0);
        expect_at(52, 0, 99, 1, 0, 0);
        expect_at(62, 0, 98, 1, 0, 0);
        expect_at(66, 0, 98, 1, 0, 0);
        expect_at(67, 1, 0, 0, 0, 0);
        expect_at(68, 1, 0, 0, 0, 0);
        set_preset(39, 6'd1, 7'd0);
        pulse(1'b0, 1'b1, 39);
        pulse(1'b1, 1'b0, 41);
        pulse(1'b1, 1'b1, 66);

        // Pause/resume on 00.50; preset change while paused is ignored.
        expect_at(70, 0, 50, 0, 0, 0);
        expect_at(72, 0, 50, 1, 0, 0);
        expect_at(81, 0, 50, 1, 0, 0);
        expect_at(82, 0, 49, 1, 0, 0);
        expect_at(92, 0, 48, 1, 0, 0);
        expect_at(96, 0, 48, 1, 0, 0);
        expect_at(97, 0, 48, 0, 0, 0);
        expect_at(196, 0, 48, 0, 0, 0);
        expect_at(198, 0, 48, 1, 0, 0);
        expect_at(202, 0, 48, 1, 0, 0);
        expect_at(203, 0, 47, 1, 0, 0);
        expect_at(206, 0, 10, 0, 0, 0);
        set_preset(69, 6'd0, 7'd50);
        pulse(1'b1, 1'b0, 71);
        pulse(1'b1, 1'b0, 96);
        set_preset(120, 6'd0, 7'd10);
        pulse(1'b1, 1'b0, 197);
        pulse(1'b0, 1'b1, 205);

        // Zero preset ignores k0; out-of-range preset clamps.
        expect_at(209, 0, 0, 0, 0, 0);
        expect_at(211, 0, 0, 0, 0, 0);
        expect_at(213, 0, 0, 0, 0, 0);
        expect_at(215, 59, 99, 0, 0, 0);
        expect_at(217, 59, 99, 0, 0, 0);
        set_preset(208, 6'd0, 7'd0);
        pulse(1'b1, 1'b0, 210);
        set_preset(214, 6'd60, 7'd100);
        set_preset(216, 6'd63, 7'd127);

        // Reset mid-run: immediate return to zero, no alarm.
        expect_at(219, 0, 2, 0, 0, 0);
        expect_at(231, 0, 1, 1, 0, 0);
        expect_at(233, 0, 0, 0, 0, 0);
        expect_at(241, 0, 0, 0, 0, 0);
        expect_at(242, 0, 0, 0, 0, 0);
        expect_at(244, 0, 2, 0, 0, 0);
        set_preset(218, 6'd0, 7'd2);
        pulse(1'b1, 1'b0, 220);
        wait_to(232);
        #2 rst_n = 1'b0;
        wait_to(243);
        rst_n = 1'b1;

        // 00.02 to expiry (or auto-reload), then leave via a key.
        expect_at(257, 0, 1, 1, 0, 0);
        expect_at(267, 0, 0, 1, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        expect_at(268, 0, 2, 1, 0, 1);
        expect_at(269, 0, 2, 1, 0, 0);
        expect_at(287, 0, 0, 1, 0, 0);
        expect_at(288, 0, 2, 1, 0, 1);
        expect_at(289, 0, 2, 1, 0, 0);
`else
        expect_at(268, 0, 0, 0, 1, 1);
        expect_at(269, 0, 0, 0, 1, 0);
        expect_at(288, 0, 0, 0, 1, 0);
`endif
        expect_at(291, 0, 2, 0, 0, 0);
        pulse(1'b1, 1'b0, 246);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        pulse(1'b0, 1'b1, 290);
`else
        pulse(1'b1, 1'b0, 290);
`endif

        // k0 on the tick that reaches zero is discarded.
        expect_at(293, 0, 1, 0, 0, 0);
        expect_at(305, 0, 0, 1, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        expect_at(306, 0, 1, 1, 0, 1);
`else
        expect_at(306, 0, 0, 0, 1, 1);
`endif
        expect_at(309, 0, 1, 0, 0, 0);
        set_preset(292, 6'd0, 7'd1);
        pulse(1'b1, 1'b0, 294);
        pulse(1'b1, 1'b0, 304);
        pulse(1'b0, 1'b1, 308);

        while (sb_q.size() != 0 && cyc < DEADLINE + 5) @(negedge clk);
        wait_to(cyc + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
